// File: rtl/lc4_issue_window.sv
// Four-slot instruction window: in-order allocate and retire, out-of-order issue.
// Slot state feeds the issue-select logic directly from registers.
module lc4_issue_window (
    input  logic        clk,
    input  logic        rst,
    input  logic        dp_valid,
    input  logic [15:0] dp_insn,
    input  logic [3:0]  dp_pr1,
    input  logic [3:0]  dp_pr2,
    input  logic [3:0]  dp_prd,
    output logic        dp_ready,
    input  logic        is_valid,
    input  logic [1:0]  is_index,
    input  logic        cm_valid,
    input  logic [1:0]  cm_index,
    input  logic        flush,
    output logic [15:0] iq0_insn,
    output logic [15:0] iq1_insn,
    output logic [15:0] iq2_insn,
    output logic [15:0] iq3_insn,
    output logic [3:0]  iq0_pr1,
    output logic [3:0]  iq1_pr1,
    output logic [3:0]  iq2_pr1,
    output logic [3:0]  iq3_pr1,
    output logic [3:0]  iq0_pr2,
    output logic [3:0]  iq1_pr2,
    output logic [3:0]  iq2_pr2,
    output logic [3:0]  iq3_pr2,
    output logic [3:0]  iq0_prd,
    output logic [3:0]  iq1_prd,
    output logic [3:0]  iq2_prd,
    output logic [3:0]  iq3_prd,
    output logic [3:0]  iq_valid,
    output logic [3:0]  iq_issue,
    output logic [3:0]  iq_commit,
    output logic [1:0]  iq_rd,
    output logic [1:0]  iq_wr,
    output logic [2:0]  iq_count,
    output logic        rt_valid,
    output logic [15:0] rt_insn,
    output logic [3:0]  rt_prd
);

    logic [15:0] insn_q [4];
    logic [3:0]  pr1_q  [4];
    logic [3:0]  pr2_q  [4];
    logic [3:0]  prd_q  [4];
    logic [3:0]  valid_q, issue_q, commit_q;
    logic [3:0]  valid_d, issue_d, commit_d;
    logic [1:0]  rd_q, wr_q;
    logic [2:0]  count_q, count_d;
    logic        dispatch, do_issue, do_commit;

    assign dp_ready = count_q != 3'd4;
    assign rt_valid = valid_q[rd_q] & commit_q[rd_q];
    assign rt_insn  = insn_q[rd_q];
    assign rt_prd   = prd_q[rd_q];

    assign dispatch  = dp_valid & dp_ready;
    // Complete sees start-of-cycle issue bits, so same-cycle issue+complete drops the complete
    assign do_issue  = is_valid & valid_q[is_index] & ~issue_q[is_index];
    assign do_commit = cm_valid & valid_q[cm_index] & issue_q[cm_index];

    always_comb begin
        valid_d  = valid_q;
        issue_d  = issue_q;
        commit_d = commit_q;
        count_d  = count_q;
        if (do_issue)
            issue_d[is_index] = 1'b1;
        if (do_commit)
            commit_d[cm_index] = 1'b1;
        if (rt_valid) begin
            valid_d[rd_q]  = 1'b0;
            issue_d[rd_q]  = 1'b0;
            commit_d[rd_q] = 1'b0;
        end
        if (dispatch) begin
            valid_d[wr_q]  = 1'b1;
            issue_d[wr_q]  = 1'b0;
            commit_d[wr_q] = 1'b0;
        end
        if (dispatch && !rt_valid)
            count_d = count_q + 3'd1;
        else if (!dispatch && rt_valid)
            count_d = count_q - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                insn_q[i] <= '0;
                pr1_q[i]  <= '0;
                pr2_q[i]  <= '0;
                prd_q[i]  <= '0;
            end
            valid_q  <= '0;
            issue_q  <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
        end else if (flush) begin
            valid_q  <= '0;
            issue_q  <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            issue_q  <= issue_d;
            commit_q <= commit_d;
            count_q  <= count_d;
            if (dispatch) begin
                insn_q[wr_q] <= dp_insn;
                pr1_q[wr_q]  <= dp_pr1;
                pr2_q[wr_q]  <= dp_pr2;
                prd_q[wr_q]  <= dp_prd;
                wr_q         <= wr_q + 2'd1;
            end
            if (rt_valid)
                rd_q <= rd_q + 2'd1;
        end
    end

    assign iq0_insn  = insn_q[0];
    assign iq1_insn  = insn_q[1];
    assign iq2_insn  = insn_q[2];
    assign iq3_insn  = insn_q[3];
    assign iq0_pr1   = pr1_q[0];
    assign iq1_pr1   = pr1_q[1];
    assign iq2_pr1   = pr1_q[2];
    assign iq3_pr1   = pr1_q[3];
    assign iq0_pr2   = pr2_q[0];
    assign iq1_pr2   = pr2_q[1];
    assign iq2_pr2   = pr2_q[2];
    assign iq3_pr2   = pr2_q[3];
    assign iq0_prd   = prd_q[0];
    assign iq1_prd   = prd_q[1];
    assign iq2_prd   = prd_q[2];
    assign iq3_prd   = prd_q[3];
    assign iq_valid  = valid_q;
    assign iq_issue  = issue_q;
    assign iq_commit = commit_q;
    assign iq_rd     = rd_q;
    assign iq_wr     = wr_q;
    assign iq_count  = count_q;

endmodule

// File: tb/tb_lc4_issue_window.sv
// Bench for lc4_issue_window: directed scenarios then random traffic,
// all checked against a slot-status reference model.
module tb_lc4_issue_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        dp_valid;
    logic [15:0] dp_insn;
    logic [3:0]  dp_pr1, dp_pr2, dp_prd;
    logic        dp_ready;
    logic        is_valid, cm_valid, flush;
    logic [1:0]  is_index, cm_index;
    logic [15:0] iq0_insn, iq1_insn, iq2_insn, iq3_insn;
    logic [3:0]  iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1;
    logic [3:0]  iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2;
    logic [3:0]  iq0_prd, iq1_prd, iq2_prd, iq3_prd;
    logic [3:0]  iq_valid, iq_issue, iq_commit;
    logic [1:0]  iq_rd, iq_wr;
    logic [2:0]  iq_count;
    logic        rt_valid;
    logic [15:0] rt_insn;
    logic [3:0]  rt_prd;

    always #5 clk = ~clk;

    lc4_issue_window dut (
        .clk(clk), .rst(rst),
        .dp_valid(dp_valid), .dp_insn(dp_insn),
        .dp_pr1(dp_pr1), .dp_pr2(dp_pr2), .dp_prd(dp_prd),
        .dp_ready(dp_ready),
        .is_valid(is_valid), .is_index(is_index),
        .cm_valid(cm_valid), .cm_index(cm_index),
        .flush(flush),
        .iq0_insn(iq0_insn), .iq1_insn(iq1_insn),
        .iq2_insn(iq2_insn), .iq3_insn(iq3_insn),
        .iq0_pr1(iq0_pr1), .iq1_pr1(iq1_pr1),
        .iq2_pr1(iq2_pr1), .iq3_pr1(iq3_pr1),
        .iq0_pr2(iq0_pr2), .iq1_pr2(iq1_pr2),
        .iq2_pr2(iq2_pr2), .iq3_pr2(iq3_pr2),
        .iq0_prd(iq0_prd), .iq1_prd(iq1_prd),
        .iq2_prd(iq2_prd), .iq3_prd(iq3_prd),
        .iq_valid(iq_valid), .iq_issue(iq_issue),
        .iq_commit(iq_commit),
        .iq_rd(iq_rd), .iq_wr(iq_wr), .iq_count(iq_count),
        .rt_valid(rt_valid), .rt_insn(rt_insn), .rt_prd(rt_prd)
    );

    logic [15:0] d_insn [4];
    logic [3:0]  d_pr1  [4];
    logic [3:0]  d_pr2  [4];
    logic [3:0]  d_prd  [4];
    assign d_insn[0] = iq0_insn;
    assign d_insn[1] = iq1_insn;
    assign d_insn[2] = iq2_insn;
    assign d_insn[3] = iq3_insn;
    assign d_pr1[0] = iq0_pr1;
    assign d_pr1[1] = iq1_pr1;
    assign d_pr1[2] = iq2_pr1;
    assign d_pr1[3] = iq3_pr1;
    assign d_pr2[0] = iq0_pr2;
    assign d_pr2[1] = iq1_pr2;
    assign d_pr2[2] = iq2_pr2;
    assign d_pr2[3] = iq3_pr2;
    assign d_prd[0] = iq0_prd;
    assign d_prd[1] = iq1_prd;
    assign d_prd[2] = iq2_prd;
    assign d_prd[3] = iq3_prd;

    // Reference model: each slot has a lifecycle status
    typedef enum int {FREE, WAITING, ISSUED, DONE} slot_st_e;
    slot_st_e    st [4];
    logic [15:0] m_insn [4];
    logic [3:0]  m_pr1 [4];
    logic [3:0]  m_pr2 [4];
    logic [3:0]  m_prd [4];
    int          m_rd, m_wr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (st[i] != FREE) n++;
        return n;
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) m[i] = st[i] != FREE;
        return m;
    endfunction

    function automatic logic [3:0] m_issue();
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) m[i] = st[i] == ISSUED || st[i] == DONE;
        return m;
    endfunction

    function automatic logic [3:0] m_commit();
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) m[i] = st[i] == DONE;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            st[i] = FREE;
            m_insn[i] = '0;
            m_pr1[i] = '0;
            m_pr2[i] = '0;
            m_prd[i] = '0;
        end
        m_rd = 0;
        m_wr = 0;
    endtask

    task automatic check_state();
        chk("iq_valid", iq_valid, m_valid());
        chk("iq_issue", iq_issue, m_issue());
        chk("iq_commit", iq_commit, m_commit());
        chk("iq_rd", iq_rd, m_rd);
        chk("iq_wr", iq_wr, m_wr);
        chk("iq_count", iq_count, occ());
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("insn%0d", i), d_insn[i], m_insn[i]);
            chk($sformatf("pr1_%0d", i), d_pr1[i], m_pr1[i]);
            chk($sformatf("pr2_%0d", i), d_pr2[i], m_pr2[i]);
            chk($sformatf("prd%0d", i), d_prd[i], m_prd[i]);
        end
    endtask

    // Called at the negedge with inputs already driven; advances one clock
    task automatic cycle();
        slot_st_e old [4];
        bit rt, disp;
        #1;
        rt   = st[m_rd] == DONE;
        disp = dp_valid && occ() != 4;
        chk("dp_ready", dp_ready, occ() != 4);
        chk("rt_valid", rt_valid, rt);
        chk("rt_insn", rt_insn, m_insn[m_rd]);
        chk("rt_prd", rt_prd, m_prd[m_rd]);
        old = st;
        if (flush) begin
            for (int i = 0; i < 4; i++) st[i] = FREE;
            m_rd = 0;
            m_wr = 0;
        end else begin
            if (is_valid && old[is_index] == WAITING) st[is_index] = ISSUED;
            if (cm_valid && old[cm_index] == ISSUED) st[cm_index] = DONE;
            if (rt) begin
                st[m_rd] = FREE;
                m_rd = (m_rd + 1) % 4;
            end
            if (disp) begin
                st[m_wr] = WAITING;
                m_insn[m_wr] = dp_insn;
                m_pr1[m_wr] = dp_pr1;
                m_pr2[m_wr] = dp_pr2;
                m_prd[m_wr] = dp_prd;
                m_wr = (m_wr + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
    endtask

    task automatic idle();
        dp_valid = 0;
        is_valid = 0;
        cm_valid = 0;
        flush = 0;
    endtask

    task automatic disp(input logic [15:0] insn, input logic [3:0] p1, p2, pd);
        dp_valid = 1;
        dp_insn = insn;
        dp_pr1 = p1;
        dp_pr2 = p2;
        dp_prd = pd;
    endtask

    task automatic iss(input logic [1:0] idx);
        is_valid = 1;
        is_index = idx;
    endtask

    task automatic cmp(input logic [1:0] idx);
        cm_valid = 1;
        cm_index = idx;
    endtask

    initial begin
        rst = 1;
        idle();
        dp_insn = '0; dp_pr1 = '0; dp_pr2 = '0; dp_prd = '0;
        is_index = '0; cm_index = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_state();
        chk("reset dp_ready", dp_ready, 1);
        chk("reset rt_valid", rt_valid, 0);

        // First dispatch
        disp(16'h1234, 4'd1, 4'd2, 4'd5);
        cycle();
        chk("d1 valid", iq_valid, 4'b0001);
        chk("d1 prd0", iq0_prd, 5);
        chk("d1 wr", iq_wr, 1);
        chk("d1 count", iq_count, 1);
        chk("d1 rt_valid", rt_valid, 0);

        // Fill, then a rejected fifth dispatch
        disp(16'h2222, 4'd3, 4'd4, 4'd6); cycle();
        disp(16'h3333, 4'd5, 4'd6, 4'd7); cycle();
        disp(16'h4444, 4'd7, 4'd8, 4'd9); cycle();
        chk("full count", iq_count, 4);
        chk("full dp_ready", dp_ready, 0);
        disp(16'h5555, 4'd9, 4'd9, 4'd9); cycle();
        chk("reject wr", iq_wr, 0);
        chk("reject count", iq_count, 4);
        idle();

        // Out-of-order completion does not retire past the head
        iss(2); cycle(); idle();
        cmp(2); cycle(); idle();
        chk("ooo commit", iq_commit, 4'b0100);
        chk("ooo rt_valid", rt_valid, 0);
        iss(0); cycle(); idle();
        cmp(0); cycle(); idle();
        chk("head rt_valid", rt_valid, 1);
        chk("head rt_prd", rt_prd, 5);
        cycle();
        chk("retire rd", iq_rd, 1);
        chk("retire count", iq_count, 3);

        // Complete unissued slot; issue+complete same slot
        cmp(1); cycle(); idle();
        chk("unissued commit", iq_commit, 4'b0100);
        iss(3); cmp(3); cycle(); idle();
        chk("same-cycle issue3", iq_issue[3], 1);
        chk("same-cycle commit3", iq_commit[3], 0);

        // Walk head to slot 3 with the window full
        iss(1); disp(16'hA000, 4'd1, 4'd1, 4'd10); cycle(); idle();
        cmp(1); cycle(); idle();
        disp(16'hA001, 4'd2, 4'd2, 4'd11); cycle();
        cycle();
        disp(16'hA002, 4'd3, 4'd3, 4'd12); cycle();
        chk("walk rd", iq_rd, 3);
        chk("walk count", iq_count, 4);
        cmp(3); cycle();
        #1;
        chk("wrap dp_ready", dp_ready, 0);
        chk("wrap rt_valid", rt_valid, 1);
        cycle();
        chk("wrap rd", iq_rd, 0);
        chk("wrap count", iq_count, 3);
        idle();
        disp(16'hA003, 4'd4, 4'd4, 4'd13); cycle(); idle();
        chk("refill slot3 insn", iq3_insn, 16'hA003);
        chk("refill count", iq_count, 4);

        // Flush with retire and dispatch pending
        iss(0); cycle(); idle();
        cmp(0); cycle(); idle();
        flush = 1;
        disp(16'hBEEF, 4'd1, 4'd1, 4'd1);
        cycle(); idle();
        chk("flush valid", iq_valid, 0);
        chk("flush rd", iq_rd, 0);
        chk("flush wr", iq_wr, 0);
        chk("flush count", iq_count, 0);

        // Asynchronous reset between edges
        disp(16'hC001, 4'd1, 4'd2, 4'd3); cycle();
        disp(16'hC002, 4'd4, 4'd5, 4'd6); cycle(); idle();
        #2 rst = 1;
        #1;
        model_reset();
        check_state();
        chk("async dp_ready", dp_ready, 1);
        chk("async rt_valid", rt_valid, 0);
        #1 rst = 0;
        @(negedge clk);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            dp_valid = $urandom_range(0, 1);
            dp_insn  = 16'($urandom);
            dp_pr1   = 4'($urandom);
            dp_pr2   = 4'($urandom);
            dp_prd   = 4'($urandom);
            is_valid = $urandom_range(0, 3) != 0;
            is_index = 2'($urandom);
            cm_valid = $urandom_range(0, 3) != 0;
            cm_index = 2'($urandom);
            flush    = $urandom_range(0, 63) == 0;
            cycle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
